// File: rtl/alu_pkg.sv
// Shared encodings for the RV32I execute sequencer: ALU opcodes, status bit
// positions, the function code seen on in_fn and the sequencer state enum.
package alu_pkg;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b1000;
   localparam logic [3:0] ALU_AND = 4'b0111;
   localparam logic [3:0] ALU_OR  = 4'b0110;
   localparam logic [3:0] ALU_XOR = 4'b0100;

   localparam int ST_CARRY  = 0;
   localparam int ST_PARITY = 1;
   localparam int ST_ZERO   = 2;
   localparam int ST_NEG    = 3;
   localparam int ST_OVF    = 4;

   typedef enum logic [3:0] {
      FN_ADD  = 4'd0,  FN_SUB  = 4'd1,  FN_AND  = 4'd2,  FN_OR   = 4'd3,
      FN_XOR  = 4'd4,  FN_SLT  = 4'd5,  FN_SLTU = 4'd6,  FN_SLL  = 4'd7,
      FN_SRL  = 4'd8,  FN_SRA  = 4'd9,  FN_BEQ  = 4'd10, FN_BNE  = 4'd11,
      FN_BLT  = 4'd12, FN_BGE  = 4'd13, FN_BLTU = 4'd14, FN_BGEU = 4'd15
   } fn_e;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_EXEC  = 2'd1,
      S_SHIFT = 2'd2,
      S_DONE  = 2'd3
   } state_e;

   // True for the three iterative shift functions.
   function automatic logic is_shift(input fn_e f);
      return (f == FN_SLL) || (f == FN_SRL) || (f == FN_SRA);
   endfunction

   // True for compares that run as a signed compare on MSB-flipped operands.
   function automatic logic is_ucmp(input fn_e f);
      return (f == FN_SLTU) || (f == FN_BLTU) || (f == FN_BGEU);
   endfunction

endpackage

// File: rtl/serial_shifter.sv
// Multi-cycle barrel-free shifter: moves at most SHIFT_STEP bits per step
// until the loaded shift amount is used up.
module serial_shifter #(
   parameter int SHIFT_STEP = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic        step,
   input  logic        left,
   input  logic        arith,
   input  logic [31:0] load_data,
   input  logic [4:0]  load_amt,
   output logic [31:0] data_nxt,
   output logic        done
);

   localparam logic [4:0] STEP = 5'(SHIFT_STEP);

   logic [31:0]        data_q;
   logic signed [31:0] sdata;
   logic [4:0]         rem_q;
   logic [4:0]         amt;
   logic [4:0]         rem_nxt;

   assign amt     = (rem_q < STEP) ? rem_q : STEP;
   assign rem_nxt = rem_q - amt;
   // Asserted on the step that consumes the last remaining bits.
   assign done    = (rem_nxt == 5'd0);
   assign sdata   = data_q;

   // Shifted value after the current step; SRA replicates the sign bit.
   always_comb begin
      if (left)
         data_nxt = data_q << amt;
      else if (arith)
         data_nxt = sdata >>> amt;
      else
         data_nxt = data_q >> amt;
   end

   // Remaining-count register (control, reset).
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         rem_q <= 5'd0;
      else if (load)
         rem_q <= load_amt;
      else if (step)
         rem_q <= rem_nxt;
   end

   // Shift data register (datapath, not reset).
   always_ff @(posedge clk) begin
      if (load)
         data_q <= load_data;
      else if (step)
         data_q <= data_nxt;
   end

endmodule

// File: rtl/alu_sequencer.sv
// Execute controller in front of the combinational ALU: sequences one
// operation at a time, adding compares, branch resolution and serial shifts.
module alu_sequencer
   import alu_pkg::*;
#(
   parameter int SHIFT_STEP = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [3:0]  in_fn,
   input  logic [31:0] in_a,
   input  logic [31:0] in_b,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [3:0]  alu_op,
   input  logic [31:0] alu_result,
   input  logic [4:0]  alu_status,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_result,
   output logic        out_taken
);

   localparam logic [31:0] MSB = 32'h8000_0000;

   state_e      state, state_nxt;
   fn_e         fn_in, fn_q;
   logic [31:0] a_q, b_q;
   logic [31:0] result_q;
   logic        taken_q;
   logic        accept;
   logic        lt, eq;
   logic [3:0]  exec_op;
   logic [31:0] exec_res;
   logic        exec_taken;
   logic [31:0] sh_nxt;
   logic        sh_done;
   logic        unused_status;

   assign fn_in         = fn_e'(in_fn);
   assign in_ready      = (state == S_IDLE) & ~rst;
   assign accept        = in_valid & in_ready;
   assign out_valid     = (state == S_DONE);
   assign out_result    = result_q;
   assign out_taken     = taken_q;
   assign alu_a         = a_q;
   assign alu_b         = b_q;
   assign alu_op        = (state == S_EXEC) ? exec_op : ALU_ADD;
   assign lt            = alu_status[ST_NEG] ^ alu_status[ST_OVF];
   assign eq            = alu_status[ST_ZERO];
   assign unused_status = ^alu_status[ST_PARITY:ST_CARRY];

   // ALU opcode required by the registered function.
   always_comb begin
      exec_op = ALU_SUB;
      case (fn_q)
         FN_ADD:                 exec_op = ALU_ADD;
         FN_AND:                 exec_op = ALU_AND;
         FN_OR:                  exec_op = ALU_OR;
         FN_XOR:                 exec_op = ALU_XOR;
         FN_SLL, FN_SRL, FN_SRA: exec_op = ALU_ADD;
         default:                exec_op = ALU_SUB;
      endcase
   end

   // Result and branch decision produced at the end of the EXEC cycle.
   always_comb begin
      exec_res   = 32'd0;
      exec_taken = 1'b0;
      case (fn_q)
         FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR: exec_res = alu_result;
         FN_SLT, FN_SLTU:                       exec_res = {31'b0, lt};
         FN_SLL, FN_SRL, FN_SRA:                exec_res = a_q;
         FN_BEQ:                                exec_taken = eq;
         FN_BNE:                                exec_taken = ~eq;
         FN_BLT, FN_BLTU:                       exec_taken = lt;
         FN_BGE, FN_BGEU:                       exec_taken = ~lt;
         default:                               exec_res = 32'd0;
      endcase
   end

   serial_shifter #(
      .SHIFT_STEP (SHIFT_STEP)
   ) u_shifter (
      .clk       (clk),
      .rst       (rst),
      .load      (accept),
      .step      (state == S_SHIFT),
      .left      (fn_q == FN_SLL),
      .arith     (fn_q == FN_SRA),
      .load_data (in_a),
      .load_amt  (in_b[4:0]),
      .data_nxt  (sh_nxt),
      .done      (sh_done)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (accept)
               state_nxt = (is_shift(fn_in) && (in_b[4:0] != 5'd0)) ? S_SHIFT : S_EXEC;
         end
         S_EXEC:  state_nxt = S_DONE;
         S_SHIFT: if (sh_done) state_nxt = S_DONE;
         S_DONE:  if (out_ready) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Operand capture on accept (MSBs flipped for unsigned compares) and
   // result capture when EXEC or the final shift step completes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fn_q     <= FN_ADD;
         a_q      <= 32'd0;
         b_q      <= 32'd0;
         result_q <= 32'd0;
         taken_q  <= 1'b0;
      end else begin
         if (accept) begin
            fn_q <= fn_in;
            a_q  <= is_ucmp(fn_in) ? (in_a ^ MSB) : in_a;
            b_q  <= is_ucmp(fn_in) ? (in_b ^ MSB) : in_b;
         end
         if (state == S_EXEC) begin
            result_q <= exec_res;
            taken_q  <= exec_taken;
         end else if ((state == S_SHIFT) && sh_done) begin
            result_q <= sh_nxt;
            taken_q  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: a behavioural ALU feeds the DUT,
// a reference model fills a scoreboard queue at issue time and a monitor
// pops and compares on every output handshake.
module tb_alu_sequencer;

   typedef struct packed {
      logic [31:0] res;
      logic        taken;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, out_valid, out_ready, out_taken;
   logic [3:0]  in_fn, alu_op;
   logic [31:0] in_a, in_b, alu_a, alu_b, alu_result, out_result;
   logic [4:0]  alu_status;

   logic        in_valid4, in_ready4, out_valid4, out_ready4, out_taken4;
   logic [3:0]  in_fn4, alu_op4;
   logic [31:0] in_a4, in_b4, alu_a4, alu_b4, alu_result4, out_result4;
   logic [4:0]  alu_status4;

   exp_t        sb[$];
   int          n_checks = 0;
   int          n_pass   = 0;
   logic [3:0]  exec_op;
   logic [31:0] exec_a, exec_b;
   int          lat;

   always #5 clk = ~clk;

   alu_sequencer #(.SHIFT_STEP(1)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_fn(in_fn), .in_a(in_a), .in_b(in_b),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
      .alu_result(alu_result), .alu_status(alu_status),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_taken(out_taken)
   );

   alu_sequencer #(.SHIFT_STEP(4)) dut4 (
      .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
      .in_fn(in_fn4), .in_a(in_a4), .in_b(in_b4),
      .alu_a(alu_a4), .alu_b(alu_b4), .alu_op(alu_op4),
      .alu_result(alu_result4), .alu_status(alu_status4),
      .out_valid(out_valid4), .out_ready(out_ready4),
      .out_result(out_result4), .out_taken(out_taken4)
   );

   // Behavioural 32-bit ALU: {status[4:0], result[31:0]}.
   function automatic logic [36:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                         input logic [3:0] op);
      logic [32:0] w;
      logic        v;
      v = 1'b0;
      case (op)
         4'b0000: begin w = {1'b0, a} + {1'b0, b};          v = (a[31] == b[31]) && (w[31] != a[31]); end
         4'b1000: begin w = {1'b0, a} + {1'b0, ~b} + 33'd1; v = (a[31] != b[31]) && (w[31] != a[31]); end
         4'b0111: w = {1'b0, a & b};
         4'b0110: w = {1'b0, a | b};
         4'b0100: w = {1'b0, a ^ b};
         default: w = 33'd0;
      endcase
      return {v, w[31], (w[31:0] == 32'd0), ^w[31:0], w[32], w[31:0]};
   endfunction

   assign {alu_status,  alu_result}  = alu_f(alu_a,  alu_b,  alu_op);
   assign {alu_status4, alu_result4} = alu_f(alu_a4, alu_b4, alu_op4);

   // Reference behaviour of each function.
   function automatic exp_t model(input logic [3:0] fn, input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      logic [4:0] sh;
      sh = b[4:0];
      e.res = 32'd0;
      e.taken = 1'b0;
      case (fn)
         4'd0:  e.res = a + b;
         4'd1:  e.res = a - b;
         4'd2:  e.res = a & b;
         4'd3:  e.res = a | b;
         4'd4:  e.res = a ^ b;
         4'd5:  e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'd6:  e.res = (a < b) ? 32'd1 : 32'd0;
         4'd7:  e.res = a << sh;
         4'd8:  e.res = a >> sh;
         4'd9:  e.res = $signed(a) >>> sh;
         4'd10: e.taken = (a == b);
         4'd11: e.taken = (a != b);
         4'd12: e.taken = ($signed(a) < $signed(b));
         4'd13: e.taken = ($signed(a) >= $signed(b));
         4'd14: e.taken = (a < b);
         default: e.taken = (a >= b);
      endcase
      return e;
   endfunction

   function automatic int exp_lat(input logic [3:0] fn, input logic [31:0] b);
      return (fn >= 4'd7 && fn <= 4'd9 && b[4:0] != 5'd0) ? int'(b[4:0]) : 1;
   endfunction

   // Scoreboard monitor: every output handshake must match the oldest expectation.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && out_valid && out_ready) begin
         n_checks++;
         if (sb.size() == 0) begin
            $display("FAIL unexpected_output result=%h taken=%b required no output", out_result, out_taken);
         end else begin
            e = sb.pop_front();
            if (out_result !== e.res || out_taken !== e.taken)
               $display("FAIL scoreboard result=%h taken=%b required result=%h taken=%b",
                        out_result, out_taken, e.res, e.taken);
            else
               n_pass++;
         end
      end
   end

   // Offer one operation, record ALU drive right after accept, return latency.
   task automatic run_op(input logic [3:0] fn, input logic [31:0] a, input logic [31:0] b,
                         output int lat_o);
      int guard;
      guard = 0;
      while (!in_ready && guard < 50) begin @(posedge clk); #1; guard++; end
      n_checks++;
      if (!in_ready) begin
         $display("FAIL accept_wait in_ready=%b required 1", in_ready);
         lat_o = -1;
         return;
      end
      n_pass++;
      in_valid = 1'b1; in_fn = fn; in_a = a; in_b = b;
      sb.push_back(model(fn, a, b));
      @(posedge clk); #1;
      in_valid = 1'b0;
      exec_op = alu_op; exec_a = alu_a; exec_b = alu_b;
      lat_o = 0;
      while (!out_valid && lat_o < 100) begin @(posedge clk); #1; lat_o++; end
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; in_fn = 4'd0; in_a = 32'd0; in_b = 32'd0; out_ready = 1'b1;
      in_valid4 = 1'b0; in_fn4 = 4'd0; in_a4 = 32'd0; in_b4 = 32'd0; out_ready4 = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_taken !== 1'b0 || out_result !== 32'd0)
         $display("FAIL reset_outputs in_ready=%b out_valid=%b taken=%b result=%h required 0 0 0 0",
                  in_ready, out_valid, out_taken, out_result);
      else n_pass++;
      n_checks++;
      if (alu_a !== 32'd0 || alu_b !== 32'd0 || alu_op !== 4'b0000)
         $display("FAIL reset_alu alu_a=%h alu_b=%h alu_op=%b required 0 0 0000", alu_a, alu_b, alu_op);
      else n_pass++;
      rst = 1'b0;
      #1;
      n_checks++;
      if (in_ready !== 1'b1) $display("FAIL reset_release in_ready=%b required 1", in_ready);
      else n_pass++;
   endtask

   task automatic test_logic_ops();
      logic [3:0]  fns [5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
      logic [3:0]  ops [5] = '{4'b0000, 4'b1000, 4'b0111, 4'b0110, 4'b0100};
      logic [31:0] as  [5] = '{32'd7, 32'd3, 32'hF0F0_1234, 32'h0F00_0001, 32'hFFFF_0000};
      logic [31:0] bs  [5] = '{32'd5, 32'd10, 32'h0FF0_FF00, 32'h00F0_0010, 32'h0F0F_F0F0};
      for (int i = 0; i < 5; i++) begin
         run_op(fns[i], as[i], bs[i], lat);
         n_checks++;
         if (lat !== 1 || exec_op !== ops[i])
            $display("FAIL op_%0d latency=%0d alu_op=%b required 1 %b", i, lat, exec_op, ops[i]);
         else n_pass++;
      end
   endtask

   task automatic test_compare();
      run_op(4'd6, 32'hFFFF_FFFF, 32'd1, lat);
      n_checks++;
      if (exec_a !== 32'h7FFF_FFFF || exec_b !== 32'h8000_0001 || exec_op !== 4'b1000)
         $display("FAIL sltu_drive alu_a=%h alu_b=%h op=%b required 7fffffff 80000001 1000",
                  exec_a, exec_b, exec_op);
      else n_pass++;
      run_op(4'd5, 32'hFFFF_FFFF, 32'd1, lat);
      n_checks++;
      if (exec_a !== 32'hFFFF_FFFF || lat !== 1)
         $display("FAIL slt_drive alu_a=%h latency=%0d required ffffffff 1", exec_a, lat);
      else n_pass++;
   endtask

   task automatic test_branch();
      logic [3:0]  fns [6] = '{4'd12, 4'd13, 4'd10, 4'd15, 4'd11, 4'd14};
      logic [31:0] as  [6] = '{32'h8000_0000, 32'h8000_0000, 32'd5, 32'h8000_0000, 32'd5, 32'h8000_0000};
      logic [31:0] bs  [6] = '{32'd1, 32'd1, 32'd5, 32'd1, 32'd5, 32'd1};
      for (int i = 0; i < 6; i++) begin
         run_op(fns[i], as[i], bs[i], lat);
         n_checks++;
         if (lat !== 1) $display("FAIL branch_%0d latency=%0d required 1", i, lat);
         else n_pass++;
      end
   endtask

   task automatic test_shift();
      run_op(4'd9, 32'h8000_0000, 32'd31, lat);
      n_checks++;
      if (lat !== 31) $display("FAIL sra31_latency latency=%0d required 31", lat);
      else n_pass++;
      run_op(4'd7, 32'd1, 32'd0, lat);
      n_checks++;
      if (lat !== 1 || exec_op !== 4'b0000)
         $display("FAIL sll0 latency=%0d alu_op=%b required 1 0000", lat, exec_op);
      else n_pass++;
      run_op(4'd8, 32'h0000_00F0, 32'h0000_0024, lat);
      n_checks++;
      if (lat !== 4) $display("FAIL srl4_step1 latency=%0d required 4", lat);
      else n_pass++;
   endtask

   task automatic test_shift_step4();
      logic [3:0]  fns [2] = '{4'd8, 4'd7};
      logic [31:0] as  [2] = '{32'h0000_00F0, 32'd1};
      logic [31:0] bs  [2] = '{32'd4, 32'd7};
      logic [31:0] rs  [2] = '{32'h0000_000F, 32'h0000_0080};
      int          ls  [2] = '{1, 2};
      int          n;
      for (int i = 0; i < 2; i++) begin
         in_valid4 = 1'b1; in_fn4 = fns[i]; in_a4 = as[i]; in_b4 = bs[i];
         @(posedge clk); #1;
         in_valid4 = 1'b0;
         n = 0;
         while (!out_valid4 && n < 20) begin @(posedge clk); #1; n++; end
         n_checks++;
         if (n !== ls[i] || out_result4 !== rs[i] || out_taken4 !== 1'b0)
            $display("FAIL step4_%0d latency=%0d result=%h taken=%b required %0d %h 0",
                     i, n, out_result4, out_taken4, ls[i], rs[i]);
         else n_pass++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      run_op(4'd0, 32'd100, 32'd23, lat);
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1; in_fn = 4'd0; in_a = 32'd9; in_b = 32'd9;
         @(posedge clk); #1;
         n_checks++;
         if (out_valid !== 1'b1 || out_result !== 32'd123 || in_ready !== 1'b0)
            $display("FAIL hold_%0d valid=%b result=%h in_ready=%b required 1 0000007b 0",
                     i, out_valid, out_result, in_ready);
         else n_pass++;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0)
         $display("FAIL release in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
      else n_pass++;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (out_valid !== 1'b0) $display("FAIL no_phantom out_valid=%b required 0", out_valid);
      else n_pass++;
   endtask

   task automatic test_reset_mid_shift();
      in_valid = 1'b1; in_fn = 4'd7; in_a = 32'd1; in_b = 32'd31;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || alu_op !== 4'b0000 || in_ready !== 1'b0)
         $display("FAIL mid_shift_reset out_valid=%b alu_op=%b in_ready=%b required 0 0000 0",
                  out_valid, alu_op, in_ready);
      else n_pass++;
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1)
         $display("FAIL after_reset out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
      else n_pass++;
      run_op(4'd0, 32'd1, 32'd1, lat);
      n_checks++;
      if (lat !== 1) $display("FAIL add_after_reset latency=%0d required 1", lat);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [3:0]  fn;
      logic [31:0] a, b;
      for (int i = 0; i < 24; i++) begin
         fn = 4'($urandom_range(0, 15));
         a  = $urandom;
         b  = (i % 3 == 0) ? a : $urandom;
         run_op(fn, a, b, lat);
         n_checks++;
         if (lat !== exp_lat(fn, b))
            $display("FAIL rand_%0d fn=%0d latency=%0d required %0d", i, fn, lat, exp_lat(fn, b));
         else n_pass++;
      end
      repeat (3) @(posedge clk);
      #1;
   endtask

   initial begin
      test_reset();
      test_logic_ops();
      test_compare();
      test_branch();
      test_shift();
      test_shift_step4();
      test_backpressure();
      test_reset_mid_shift();
      test_back_to_back();
      n_checks++;
      if (sb.size() !== 0) $display("FAIL scoreboard_drain pending=%0d required 0", sb.size());
      else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle execute controller sitting upstream of the 32-bit combinational ALU in the RV32I datapath. It accepts an operation and two operands over a valid/ready handshake. It drives the ALU's A/B/op inputs and reads back the ALU result and 5-bit status. It adds the functions the ALU lacks: set-less-than, branch resolution and iterative shifts. One result or branch decision is returned per accepted operation.

## Interface
- SHIFT_STEP, 1, bits shifted per SHIFT cycle; legal values 1, 2, 4, 8.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operation offered.
- in_ready  out  1  sequencer idle and able to accept.
- in_fn  in  4  function: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 SLL, 8 SRL, 9 SRA, 10 BEQ, 11 BNE, 12 BLT, 13 BGE, 14 BLTU, 15 BGEU.
- in_a, in_b  in  32  operands (rs1, rs2/imm).
- alu_a, alu_b  out  32  ALU operands.
- alu_op  out  4  ALU op: ADD 0000, SUB 1000, AND 0111, OR 0110, XOR 0100.
- alu_result  in  32  ALU result (combinational from alu_a/alu_b/alu_op).
- alu_status  in  5  [0] carry, [1] parity, [2] zero, [3] negative, [4] overflow.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_result  out  32  result; 0 for branch functions.
- out_taken  out  1  branch taken; 0 for non-branch functions.

## Operation
- States: IDLE, EXEC, SHIFT, DONE.
- in_ready = (state==IDLE) & ~rst.
- Accept happens on in_valid & in_ready. On accept, in_fn, in_a and in_b are registered.
- Shifts with in_b[4:0] != 0 go to SHIFT. All other functions go to EXEC.
- EXEC lasts one cycle and drives alu_a/alu_b/alu_op from the registers. At the closing edge the sequencer captures the outcome and moves to DONE.
- ADD/SUB/AND/OR/XOR map directly to the ALU op. out_result = alu_result.
- SLT, BLT, BGE, BEQ, BNE use ALU SUB. lt = status[3] ^ status[4]; eq = status[2].
- SLTU, BLTU, BGEU use ALU SUB with both operand MSBs inverted (A^32'h80000000, B^32'h80000000). This turns the unsigned compare into a signed compare; lt is computed as above.
- The carry and parity status bits are never used.
- SLT/SLTU result = {31'b0, lt}.
- Branch outcomes: BEQ eq, BNE ~eq, BLT/BLTU lt, BGE/BGEU ~lt.
- Shifts with shamt 0 take the EXEC path and return in_a unchanged. The ALU is not used for the result in that case; it is driven with ADD.
- SHIFT holds the shift register and the remaining count. Each cycle it shifts by min(SHIFT_STEP, remaining). SLL and SRL fill with 0; SRA fills with the sign bit. When remaining reaches 0 it goes to DONE.
- DONE holds out_valid=1 with out_result and out_taken stable until out_ready. On out_valid & out_ready it returns to IDLE. The next accept is no earlier than the following cycle; there is no same-cycle turnaround.
- Outside EXEC, alu_op = ADD (0000) and alu_a/alu_b keep their last registered values.

## Timing
- Accept edge E0.
- EXEC path: out_valid rises after E1, so latency is 1 cycle.
- Shift path: out_valid rises after E(ceil(shamt/SHIFT_STEP)). Example: SLL by 31 with SHIFT_STEP=1 gives out_valid after E31.
- Throughput: at most one operation per 3 cycles (accept, EXEC, DONE handshake).
- Reset values: state IDLE; out_valid 0; out_result 0; out_taken 0; alu_a 0; alu_b 0; alu_op 0000; in_ready 0 while rst is high and 1 afterward.
- Reset asserted mid-EXEC, mid-SHIFT or in DONE discards the operation immediately. No output is produced for it.
- in_valid while not idle is ignored. The upstream must hold its inputs until in_ready.
- out_ready while out_valid=0 has no effect.

## Structure
- Package alu_pkg holds:
  - ALU op constants: ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR.
  - Status bit indices: ST_CARRY 0, ST_PARITY 1, ST_ZERO 2, ST_NEG 3, ST_OVF 4.
  - The 4-bit fn encoding.
  - The state enum.
- One sub-module, serial_shifter: load, step, direction and arithmetic controls, SHIFT_STEP parameter, done flag. The FSM, operand muxing and compare logic stay in alu_sequencer.

## Test plan
- ADD 7 + 5, out_ready=1 → alu_op=0000 during EXEC; out_result=12, out_taken=0, out_valid one cycle after accept.
- SLTU with A=0xFFFFFFFF, B=1 → out_result=0. SLT with the same operands → out_result=1. Check alu_a=0x7FFFFFFF and alu_b=0x80000001 during the SLTU EXEC cycle.
- BLT with A=0x80000000, B=1 (subtract overflows) → out_taken=1. BGE with the same operands → 0. BEQ 5,5 → 1. BGEU with A=0x80000000, B=1 → 1.
- SRA of 0x80000000 by 31 with SHIFT_STEP=1 → out_result=0xFFFFFFFF, out_valid after E31. SLL of 1 by 0 → 1 after E1. SRL of 0xF0 by 4 with SHIFT_STEP=4 → 0x0F after E1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → out_result stable, in_ready=0, a new in_valid is not accepted. Release → IDLE next cycle.
- Assert rst mid-SHIFT (cycle 10 of a 31-bit shift) → out_valid=0 and alu_op=0000 immediately. After release, a fresh ADD 1+1 returns 2.
